alu64_sequencer: RTL and testbench

- Controller that runs 64-bit ADD/SUB/AND/ORR operations on the shared 32-bit ALU by issuing two passes: low word, then high word.
- For ADD/SUB, the carry from the low word is chained into the high-word pass through the ALU's carry-in path (ALUControl[2]=1).
- Sits between a 64-bit requester (e.g. long-multiply accumulate or 64-bit compare logic) and the ALU instance. The ALU is external; this block drives its operand/control inputs and samples its result/flags.
- Uses valid/ready handshakes on both the request and response sides.

---
 rtl/alu64_sequencer.sv | 138 +++++++++++++
 tb/tb_alu64_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu64_sequencer.sv
// Sequences 64-bit ADD/SUB/AND/ORR through an external 32-bit ALU as a low-word
// pass then a high-word pass, chaining the low carry into the high pass.
module alu64_sequencer #(
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [31:0] alu_srca,
  output logic [31:0] alu_srcb,
  output logic [2:0]  alu_ctrl,
  output logic        alu_carry,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic [1:0]  op_q;
  logic [31:0] lo_res_q;
  logic        lo_z_q;
  logic        lo_c_q;
  logic        rsp_valid_q;
  logic [63:0] rsp_result_q;
  logic [3:0]  rsp_flags_q;
  logic [31:0] srca_q;
  logic [31:0] srcb_q;
  logic [2:0]  ctrl_q;
  logic        carry_q;
  logic        accept_s;

  // ALUControl encoding; bit 2 selects the external carry-in for the arithmetic high pass
  function automatic logic [2:0] ctrl_enc(input logic [1:0] op, input logic hi);
    case (op)
      2'b00:   ctrl_enc = hi ? 3'b100 : 3'b000;
      2'b01:   ctrl_enc = hi ? 3'b101 : 3'b001;
      2'b10:   ctrl_enc = 3'b010;
      2'b11:   ctrl_enc = 3'b011;
      default: ctrl_enc = 3'b000;
    endcase
  endfunction

  assign req_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & rsp_ready);
  assign accept_s   = req_valid & req_ready;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign alu_srca   = srca_q;
  assign alu_srcb   = srcb_q;
  assign alu_ctrl   = ctrl_q;
  assign alu_carry  = carry_q;

  // Sequencer FSM; ALU drive is registered one edge ahead so it is valid for the whole pass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      a_q          <= 64'd0;
      b_q          <= 64'd0;
      op_q         <= 2'd0;
      lo_res_q     <= 32'd0;
      lo_z_q       <= 1'b0;
      lo_c_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 64'd0;
      rsp_flags_q  <= 4'd0;
      srca_q       <= 32'd0;
      srcb_q       <= 32'd0;
      ctrl_q       <= 3'd0;
      carry_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_IDLE;
        end
        S_LO: begin
          lo_res_q <= alu_result;
          lo_z_q   <= alu_flags[2];
          lo_c_q   <= alu_flags[1];
          srca_q   <= a_q[63:32];
          srcb_q   <= b_q[63:32];
          ctrl_q   <= ctrl_enc(op_q, 1'b1);
          carry_q  <= alu_flags[1];
          state_q  <= S_HI;
        end
        S_HI: begin
          rsp_result_q <= {alu_result, lo_res_q};
          rsp_flags_q  <= {alu_flags[3], alu_flags[2] & lo_z_q, alu_flags[1], alu_flags[0]};
          rsp_valid_q  <= 1'b1;
          state_q      <= S_DONE;
          if (ZERO_IDLE) begin
            srca_q  <= 32'd0;
            srcb_q  <= 32'd0;
            ctrl_q  <= 3'd0;
            carry_q <= 1'b0;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Acceptance (from IDLE, or from DONE while the result drains) overrides the above
      if (accept_s) begin
        a_q     <= req_a;
        b_q     <= req_b;
        op_q    <= req_op;
        srca_q  <= req_a[31:0];
        srcb_q  <= req_b[31:0];
        ctrl_q  <= ctrl_enc(req_op, 1'b0);
        carry_q <= 1'b0;
        state_q <= S_LO;
      end
    end
  end

endmodule

// File: tb/tb_alu64_sequencer.sv
// Bench for alu64_sequencer: models the external 32-bit ALU and checks results
// against a direct 64-bit arithmetic reference.
module tb_alu64_sequencer;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [2:0]  alu_ctrl;
  logic        alu_carry;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;

  int errors = 0;
  int checks = 0;

  alu64_sequencer #(.ZERO_IDLE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_carry(alu_carry), .alu_result(alu_result), .alu_flags(alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: ctrl[1:0] selects ADD/SUB/AND/ORR, ctrl[2] takes carry-in from alu_carry
  logic [32:0] alu_sum;
  logic        alu_cin;
  always_comb begin
    alu_cin = alu_ctrl[2] ? alu_carry : alu_ctrl[0];
    alu_sum = 33'd0;
    alu_result = 32'd0;
    alu_flags = 4'd0;
    case (alu_ctrl[1:0])
      2'b00: begin
        alu_sum = {1'b0, alu_srca} + {1'b0, alu_srcb} + {32'd0, alu_cin};
        alu_result = alu_sum[31:0];
        alu_flags = {alu_result[31], alu_result == 32'd0, alu_sum[32],
                     (alu_srca[31] == alu_srcb[31]) && (alu_result[31] != alu_srca[31])};
      end
      2'b01: begin
        alu_sum = {1'b0, alu_srca} + {1'b0, ~alu_srcb} + {32'd0, alu_cin};
        alu_result = alu_sum[31:0];
        alu_flags = {alu_result[31], alu_result == 32'd0, alu_sum[32],
                     (alu_srca[31] != alu_srcb[31]) && (alu_result[31] != alu_srca[31])};
      end
      2'b10: begin
        alu_result = alu_srca & alu_srcb;
        alu_flags = {alu_result[31], alu_result == 32'd0, 1'b0, 1'b0};
      end
      default: begin
        alu_result = alu_srca | alu_srcb;
        alu_flags = {alu_result[31], alu_result == 32'd0, 1'b0, 1'b0};
      end
    endcase
  end

  // Reference: whole 64-bit operation, returns {N,Z,C,V,result}
  function automatic logic [67:0] ref64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] r;
    logic c;
    logic v;
    s = 65'd0;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0];
        c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      2'b01: begin
        r = a - b;
        c = (a >= b);
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      2'b10: begin r = a & b; c = 1'b0; v = 1'b0; end
      default: begin r = a | b; c = 1'b0; v = 1'b0; end
    endcase
    return {r[63], r == 64'd0, c, v, r};
  endfunction

  // Drives one request from IDLE and completes its response handshake
  task automatic do_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output logic [3:0] fl, output int lat,
                       output logic [2:0] lo_ctrl, output logic [2:0] hi_ctrl, output logic hi_carry);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    req_op = 2'($urandom_range(0, 3));
    lo_ctrl = alu_ctrl; hi_ctrl = 3'd0; hi_carry = 1'b0; lat = 0;
    while (!rsp_valid && lat < 10) begin
      if (lat == 1) begin hi_ctrl = alu_ctrl; hi_carry = alu_carry; end
      @(posedge clk); #1;
      lat++;
    end
    res = rsp_result; fl = rsp_flags;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = 64'd0; req_b = 64'd0; rsp_ready = 1'b0;
    #3;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_result !== 64'd0 || rsp_flags !== 4'd0) begin errors++; $display("FAIL reset_rsp_data: got %h/%b expected 0/0000", rsp_result, rsp_flags); end
    checks++; if ({alu_srca, alu_srcb, alu_ctrl, alu_carry} !== 68'd0) begin errors++; $display("FAIL reset_alu_drive: got %h %h %b %b expected zeros", alu_srca, alu_srcb, alu_ctrl, alu_carry); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_rsp_valid: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    logic [63:0] as  [6] = '{64'h00000000_FFFFFFFF, 64'h7FFFFFFF_FFFFFFFF, 64'd0,
                             64'h12345678_9ABCDEF0, 64'hF0F0F0F0_00000000, 64'hF0F0F0F0_00000000};
    logic [63:0] bs  [6] = '{64'd1, 64'd1, 64'd1, 64'h12345678_9ABCDEF0,
                             64'hFF00FF00_FFFFFFFF, 64'hFF00FF00_FFFFFFFF};
    logic [63:0] er  [6] = '{64'h00000001_00000000, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF,
                             64'd0, 64'hF000F000_00000000, 64'hFFF0FFF0_FFFFFFFF};
    logic [3:0]  ef  [6] = '{4'b0000, 4'b1001, 4'b1000, 4'b0110, 4'b1000, 4'b1000};
    logic        ec  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  elo [6] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b011};
    logic [2:0]  ehi [6] = '{3'b100, 3'b100, 3'b101, 3'b101, 3'b010, 3'b011};
    logic [63:0] res; logic [3:0] fl; int lat; logic [2:0] loc; logic [2:0] hic; logic hcy;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], as[i], bs[i], res, fl, lat, loc, hic, hcy);
      checks++; if (res !== er[i]) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, res, er[i]); end
      checks++; if (fl !== ef[i]) begin errors++; $display("FAIL dir%0d_flags: got %b expected %b", i, fl, ef[i]); end
      checks++; if (lat != 2) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 2", i, lat); end
      checks++; if (loc !== elo[i] || hic !== ehi[i]) begin errors++; $display("FAIL dir%0d_ctrl: got %b/%b expected %b/%b", i, loc, hic, elo[i], ehi[i]); end
      checks++; if (hcy !== ec[i]) begin errors++; $display("FAIL dir%0d_hi_carry: got %b expected %b", i, hcy, ec[i]); end
      checks++; if ({alu_srca, alu_srcb, alu_ctrl, alu_carry} !== 68'd0) begin errors++; $display("FAIL dir%0d_idle_drive: got %h %h %b %b expected zeros", i, alu_srca, alu_srcb, alu_ctrl, alu_carry); end
    end
  endtask

  task automatic test_random();
    logic [63:0] res; logic [3:0] fl; int lat; logic [2:0] loc; logic [2:0] hic; logic hcy;
    logic [1:0] op; logic [63:0] a; logic [63:0] b; logic [67:0] exp;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 5 == 1) b = a;
      if (i % 5 == 2) a[31:0] = 32'hFFFFFFFF;
      if (i % 5 == 3) b[31:0] = a[31:0];
      exp = ref64(op, a, b);
      do_op(op, a, b, res, fl, lat, loc, hic, hcy);
      checks++; if ({fl, res} !== exp) begin errors++; $display("FAIL rand%0d op%0d: got %b/%h expected %b/%h", i, op, fl, res, exp[67:64], exp[63:0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a1; logic [63:0] b1; logic [63:0] a2; logic [63:0] b2;
    logic [67:0] e1; logic [67:0] e2; int n;
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    e1 = ref64(2'b01, a1, b1); e2 = ref64(2'b00, a2, b2);
    req_valid = 1'b1; req_op = 2'b01; req_a = a1; req_b = b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_op = 2'b00; req_a = a2; req_b = b2;
    n = 0;
    while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (n != 2) begin errors++; $display("FAIL bp_first_latency: got %0d expected 2", n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || {rsp_flags, rsp_result} !== e1) begin errors++; $display("FAIL bp_hold%0d: got %b %b/%h expected 1 %b/%h", i, rsp_valid, rsp_flags, rsp_result, e1[67:64], e1[63:0]); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready%0d: got %b expected 0", i, req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || alu_ctrl !== 3'b000 || alu_srca !== a2[31:0]) begin errors++; $display("FAIL bp_second_accept: got %b %b %h expected 0 000 %h", rsp_valid, alu_ctrl, alu_srca, a2[31:0]); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_second_early: got %b expected 0", rsp_valid); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || {rsp_flags, rsp_result} !== e2) begin errors++; $display("FAIL bp_second_result: got %b %b/%h expected 1 %b/%h", rsp_valid, rsp_flags, rsp_result, e2[67:64], e2[63:0]); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [67:0] q[$];
    logic [67:0] exp;
    int last_done = -1;
    int done = 0;
    int cyc = 0;
    logic acc;
    rsp_ready = 1'b1; req_valid = 1'b1;
    req_op = 2'($urandom_range(0, 3)); req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    while (cyc < 50) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_spurious: got response %h expected none", rsp_result);
        end else begin
          exp = q.pop_front();
          checks++; if ({rsp_flags, rsp_result} !== exp) begin errors++; $display("FAIL b2b_result%0d: got %b/%h expected %b/%h", done, rsp_flags, rsp_result, exp[67:64], exp[63:0]); end
        end
        if (last_done >= 0) begin
          checks++; if (cyc - last_done != 3) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 3", done, cyc - last_done); end
        end
        last_done = cyc; done++;
      end
      acc = req_valid && req_ready;
      if (acc) q.push_back(ref64(req_op, req_a, req_b));
      if (cyc == 38) req_valid = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        req_op = 2'($urandom_range(0, 3)); req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
      end
    end
    rsp_ready = 1'b0;
    checks++; if (q.size() != 0 || done < 12) begin errors++; $display("FAIL b2b_drain: got %0d pending %0d done expected 0 pending >=12 done", q.size(), done); end
  endtask

  task automatic test_reset_midop();
    logic [63:0] res; logic [3:0] fl; int lat; logic [2:0] loc; logic [2:0] hic; logic hcy;
    req_valid = 1'b1; req_op = 2'b00; req_a = 64'h11111111_22222222; req_b = 64'h33333333_44444444;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (alu_ctrl !== 3'b100 || alu_srca !== 32'h11111111) begin errors++; $display("FAIL midop_in_hi: got %b %h expected 100 11111111", alu_ctrl, alu_srca); end
    reset_n = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 64'd0) begin errors++; $display("FAIL midop_rsp_cleared: got %b %h expected 0 0", rsp_valid, rsp_result); end
    checks++; if ({alu_srca, alu_srcb, alu_ctrl, alu_carry} !== 68'd0) begin errors++; $display("FAIL midop_alu_cleared: got %h %h %b %b expected zeros", alu_srca, alu_srcb, alu_ctrl, alu_carry); end
    @(posedge clk); #2;
    reset_n = 1'b1; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midop_req_ready: got %b expected 1", req_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_no_emit%0d: got %b expected 0", i, rsp_valid); end
    end
    do_op(2'b00, 64'd2, 64'd3, res, fl, lat, loc, hic, hcy);
    checks++; if (res !== 64'd5 || fl !== 4'b0000 || lat != 2) begin errors++; $display("FAIL midop_fresh_add: got %h/%b lat %0d expected 5/0000 lat 2", res, fl, lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

endmodule
